// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated RV32I data memory with load/store decode; define DMEM_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses
module dmem_responder #(
   parameter int MEM_WORDS   = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);
   localparam int AW = $clog2(MEM_WORDS);
   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
   state_t state, state_n;
   logic [3:0]    cnt;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   mem [MEM_WORDS];
   logic [31:0]   rdata_q;
   logic          err_q;
   logic [AW-1:0] idx;
   logic [31:0]   word, bsh, ld_data, st_mask, st_val, st_word;
   logic [15:0]   half;
   logic [7:0]    byt;
   logic          legal, mis, err;
   logic          unused_addr;
   assign unused_addr = ^req_addr[31:AW+2];
   assign req_ready = state == IDLE;
   assign busy      = state != IDLE;
   assign rsp_valid = state == RESP;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign idx   = addr_q[AW+1:2];
   assign word  = mem[idx];
   assign legal = we_q ? f3_q inside {3'b000, 3'b001, 3'b010}
                       : f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`ifdef DMEM_MISALIGN_TRAP_EN
   assign mis = (f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif
   assign err  = !legal || mis;
   assign bsh  = word >> {addr_q[1:0], 3'b000};
   assign byt  = bsh[7:0];
   assign half = addr_q[1] ? word[31:16] : word[15:0];
   assign ld_data = (err || we_q)       ? 32'h0 :
                    f3_q == 3'b000      ? {{24{byt[7]}}, byt} :
                    f3_q == 3'b001      ? {{16{half[15]}}, half} :
                    f3_q == 3'b010      ? word :
                    f3_q == 3'b100      ? {24'h0, byt} : {16'h0, half};
   assign st_mask = f3_q[1] ? 32'hFFFF_FFFF :
                    f3_q[0] ? (addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) :
                    32'hFF << {addr_q[1:0], 3'b000};
   assign st_val  = f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
   assign st_word = (word & ~st_mask) | (st_val & st_mask);
   always_comb begin
      state_n = state;
      state_n = state == IDLE   ? (req_valid ? (WAIT_CYCLES > 0 ? WAIT : ACCESS) : IDLE) :
                state == WAIT   ? (cnt == 4'(WAIT_CYCLES - 1) ? ACCESS : WAIT) :
                state == ACCESS ? RESP :
                (rsp_ready ? IDLE : RESP);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
      end else begin
         state <= state_n;
         if (req_valid && req_ready) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
            cnt     <= '0;
         end
         if (state == WAIT) cnt <= cnt + 4'd1;
         if (state == ACCESS) begin
            rdata_q <= ld_data;
            err_q   <= err;
            if (we_q && !err) mem[idx] <= st_word;
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder (WAIT_CYCLES=2, MEM_WORDS=256)
module tb_dmem_responder;
   localparam int W = 2;
   logic        clk = 0;
   logic        rst = 1;
   logic        req_valid = 0, req_we = 0, rsp_ready = 0;
   logic [2:0]  req_funct3 = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic [32:0] exp_q[$];
   int          checks = 0, errors = 0;
   logic        seen;
   dmem_responder #(.MEM_WORDS(256), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int hold);
      int lat;
      logic [32:0] exp, snap;
      exp_q.push_back({ee, er});
      @(negedge clk);
      req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      check("req_ready_idle", 35'(req_ready), 35'd1);
      @(posedge clk);
      #1 req_valid = 0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) check("busy_in_wait", {33'd0, busy, req_ready}, 35'b10);
      end while (!rsp_valid && lat < 40);
      check("latency", 35'(lat), 35'(W + 2));
      snap = {rsp_err, rsp_rdata};
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_stable", {rsp_valid, req_ready, rsp_err, rsp_rdata}, {2'b10, snap});
      end
      exp = exp_q.pop_front();
      check("rsp_data_err", {2'b00, rsp_err, rsp_rdata}, {2'b00, exp});
      rsp_ready = 1;
      @(posedge clk);
      #1 check("back_to_idle", {33'd0, rsp_valid, req_ready}, 35'b01);
      rsp_ready = 0;
   endtask
   initial begin
      repeat (3) @(negedge clk);
      rst = 0;
      check("reset_outputs", {busy, req_ready, rsp_valid, rsp_err, rsp_rdata[30:0]}, 35'h4_0000_0000 >> 1);
      xact(1, 3'b010, 32'h10, 32'h8000_00F1, 32'h0, 0, 0);
      xact(0, 3'b010, 32'h10, 32'h0, 32'h8000_00F1, 0, 0);
      xact(1, 3'b000, 32'h12, 32'h0000_00AA, 32'h0, 0, 0);
      xact(0, 3'b000, 32'h12, 32'h0, 32'hFFFF_FFAA, 0, 5);
      xact(0, 3'b100, 32'h12, 32'h0, 32'h0000_00AA, 0, 0);
      xact(0, 3'b001, 32'h12, 32'h0, 32'hFFFF_80AA, 0, 0);
      xact(0, 3'b101, 32'h10, 32'h0, 32'h0000_00F1, 0, 0);
      xact(1, 3'b001, 32'h16, 32'h1234_BEEF, 32'h0, 0, 0);
      xact(0, 3'b010, 32'h14, 32'h0, 32'hBEEF_0000, 0, 0);
      xact(1, 3'b010, 32'h400, 32'h1234_5678, 32'h0, 0, 0);
      xact(0, 3'b010, 32'h0, 32'h0, 32'h1234_5678, 0, 0);
      xact(1, 3'b010, 32'h20, 32'hCAFE_F00D, 32'h0, 0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
      xact(0, 3'b010, 32'h22, 32'h0, 32'h0, 1, 0);
      xact(0, 3'b001, 32'h11, 32'h0, 32'h0, 1, 0);
`else
      xact(0, 3'b010, 32'h22, 32'h0, 32'hCAFE_F00D, 0, 0);
      xact(0, 3'b001, 32'h11, 32'h0, 32'h0000_00F1, 0, 0);
`endif
      xact(0, 3'b011, 32'h20, 32'h0, 32'h0, 1, 0);
      xact(1, 3'b011, 32'h20, 32'hFFFF_FFFF, 32'h0, 1, 0);
      xact(0, 3'b010, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 0);
      // abort a store in WAIT; no response may follow and memory comes back cleared
      @(negedge clk);
      req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 req_valid = 0;
      @(negedge clk);
      check("abort_in_wait", {34'd0, busy}, 35'd1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) check("reset_mid_outputs", {busy, req_ready, rsp_valid, rsp_err, rsp_rdata[30:0]}, 35'h2_0000_0000);
         if (rsp_valid) seen = 1;
         @(negedge clk);
      end
      check("no_abort_rsp", {34'd0, seen}, 35'd0);
      xact(0, 3'b010, 32'h20, 32'h0, 32'h0, 0, 0);
      xact(0, 3'b010, 32'h10, 32'h0, 32'h0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 256, meaning the number of 32-bit storage words (power of two).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted before each access (0..15).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1, meaning a request is present.
REQ-006 The block SHALL have port req_ready, output, 1, meaning a request can be accepted.
REQ-007 The block SHALL have port req_we, input, 1, meaning store when 1 and load when 0.
REQ-008 The block SHALL have port req_funct3, input, 3, meaning the RV32I load/store width and sign code.
REQ-009 The block SHALL have port req_addr, input, 32, meaning the byte address.
REQ-010 The block SHALL have port req_wdata, input, 32, meaning store data, with the LSB-aligned byte/half/word taken from it.
REQ-011 The block SHALL have port rsp_valid, output, 1, meaning a response is present.
REQ-012 The block SHALL have port rsp_ready, input, 1, meaning the requester accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32, meaning extended load data, or 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err, output, 1, meaning the request was rejected (illegal funct3 or, if enabled, misaligned).
REQ-015 The block SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT, ACCESS and RESP; req_ready=1 only in IDLE.
REQ-017 A request SHALL be accepted on the edge where req_valid && req_ready; req_we, funct3, addr and wdata are latched on that edge.
REQ-018 On acceptance, the FSM SHALL go IDLE->WAIT if WAIT_CYCLES>0, else IDLE->ACCESS.
REQ-019 WAIT SHALL count WAIT_CYCLES cycles, then go to ACCESS.
REQ-020 ACCESS SHALL last exactly one cycle, then go to RESP.
REQ-021 rsp_valid SHALL first be high WAIT_CYCLES+2 cycles after the acceptance edge.
REQ-022 rsp_rdata and rsp_err SHALL be stable while rsp_valid is high.
REQ-023 The FSM SHALL stay in RESP until rsp_ready is 1; on that edge it goes RESP->IDLE, and a new request is accepted no earlier than the following cycle.
REQ-024 The word index SHALL be req_addr[log2(MEM_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo MEM_WORDS*4.
REQ-025 Byte order SHALL be little-endian.
REQ-026 Byte lane selection SHALL use addr[1:0] for bytes and addr[1] for halves.
REQ-027 Loads SHALL decode funct3 as: 000 LB (sign-extended), 001 LH (sign-extended), 010 LW, 100 LBU (zero-extended), 101 LHU (zero-extended).
REQ-028 Stores SHALL decode funct3 as: 000 SB, 001 SH, 010 SW; only the addressed lanes are modified.
REQ-029 Any other funct3 SHALL give rsp_err=1, rsp_rdata=0 and no memory change.
REQ-030 A store SHALL commit at the ACCESS->RESP edge and SHALL still produce a response (rsp_rdata=0, rsp_err=0).
REQ-031 Memory contents SHALL be visible to a load the cycle after a store commits.

Reset
REQ-032 rst SHALL force IDLE and clear the wait counter and all latched request fields.
REQ-033 rst SHALL drive req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and busy=0 from the next cycle.
REQ-034 rst SHALL clear every memory word to 0.
REQ-035 A rst asserted during WAIT or ACCESS SHALL abort the request with no write committed and no response issued.
REQ-036 rst SHALL take priority over every other event.

Configuration
REQ-037 With DMEM_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL give rsp_err=1, rsp_rdata=0 and no write, at normal latency.
REQ-038 Without DMEM_MISALIGN_TRAP_EN, addr[0] SHALL be ignored for halfwords and addr[1:0] for words (access forced aligned), and rsp_err SHALL flag only illegal funct3.

Verification
REQ-039 With WAIT_CYCLES=2, SW 0x8000_00F1 @0x10 then LW @0x10 SHALL give rsp_rdata=0x8000_00F1, rsp_err=0, with rsp_valid exactly 4 cycles after each acceptance.
REQ-040 After SW 0x8000_00F1 @0x10, the sequence SB 0xAA @0x12 then LB @0x12, LBU @0x12, LH @0x12, LHU @0x10 SHALL give 0xFFFF_FFAA, 0x0000_00AA, 0xFFFF_80AA and 0x0000_00F1 respectively.
REQ-041 Holding rsp_ready=0 for 5 cycles in RESP SHALL keep rsp_valid=1 with stable data and req_ready=0; releasing it SHALL return to IDLE on the next edge.
REQ-042 With MEM_WORDS=256, SW 0x1234_5678 @0x400 followed by LW @0x0 SHALL return 0x1234_5678 (wrap).
REQ-043 Asserting rst in WAIT during SW 0xFFFF_FFFF @0x20, then LW @0x20, SHALL return 0x0000_0000, with no response issued for the aborted store.
REQ-044 LW @0x22 SHALL give rsp_err=1, rsp_rdata=0 with DMEM_MISALIGN_TRAP_EN defined, and SHALL give the word at 0x20 with rsp_err=0 without it; funct3=011 SHALL give rsp_err=1 in both builds.
